// File: rtl/bicubic_addr_gen.sv
// Address/phase generator for the 4-bank bicubic line buffer: fills one source line, then issues 4-tap reads.
// Optional BICUBIC_CENTER_ALIGN_EN selects pixel-centre alignment of the source coordinate.
module bicubic_addr_gen #(
  parameter int DATA_WIDTH    = 24,
  parameter int ADDRESS_WIDTH = 11,
  parameter int FRAC_WIDTH    = 8,
  parameter int STEP_WIDTH    = 16,
  parameter int RAM_LATENCY   = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] src_width,
  input  logic [ADDRESS_WIDTH-1:0] dst_width,
  input  logic [STEP_WIDTH-1:0]    step,
  input  logic                     pix_valid,
  input  logic [DATA_WIDTH-1:0]    pix_data,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     we_out,
  output logic [ADDRESS_WIDTH-1:0] addrA_out,
  output logic [ADDRESS_WIDTH-1:0] addrB_out,
  output logic [ADDRESS_WIDTH-1:0] addrC_out,
  output logic [ADDRESS_WIDTH-1:0] addrD_out,
  output logic [FRAC_WIDTH-1:0]    frac_out,
  output logic                     edge_l,
  output logic                     edge_r1,
  output logic                     edge_r2,
  output logic                     tap_valid,
  output logic                     busy,
  output logic                     line_done
);

  localparam int ACC_W = ADDRESS_WIDTH + FRAC_WIDTH + 1;
  localparam int SB_W  = FRAC_WIDTH + 4;
  localparam int DC_W  = $clog2(RAM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, FILL, READ, DRAIN} state_t;

  state_t                   state_q;
  logic [ADDRESS_WIDTH-1:0] w_q, d_q, wcnt_q, tcnt_q;
  logic [STEP_WIDTH-1:0]    step_q;
  logic [ACC_W-1:0]         acc_q;
  logic [DC_W-1:0]          dcnt_q;
  logic [SB_W-1:0]          sb_q [RAM_LATENCY];

  logic [ACC_W-1:0]         acc_init_d;
  logic [ADDRESS_WIDTH:0]   x_raw;
  logic                     clamp;
  logic [ADDRESS_WIDTH-1:0] x_d;
  logic [FRAC_WIDTH-1:0]    f_d;
  logic                     el_d, er1_d, er2_d;
  logic [SB_W-1:0]          sb_d;

`ifdef BICUBIC_CENTER_ALIGN_EN
  logic [STEP_WIDTH-1:0] half_step;
  logic [STEP_WIDTH-1:0] half_pix;
  always_comb begin
    half_step  = step >> 1;
    half_pix   = STEP_WIDTH'(1) << (FRAC_WIDTH - 1);
    acc_init_d = '0;
    // Negative start offsets (step < 1.0) saturate to the first pixel.
    if (half_step >= half_pix) acc_init_d = ACC_W'(half_step - half_pix);
  end
`else
  always_comb acc_init_d = '0;
`endif

  always_comb begin
    x_raw = acc_q[ACC_W-1:FRAC_WIDTH];
    clamp = x_raw > ({1'b0, w_q} - (ADDRESS_WIDTH+1)'(1));
    x_d   = clamp ? (w_q - ADDRESS_WIDTH'(1)) : x_raw[ADDRESS_WIDTH-1:0];
    f_d   = clamp ? '0 : acc_q[FRAC_WIDTH-1:0];
    el_d  = (x_d == '0);
    er1_d = ({1'b0, x_d} + (ADDRESS_WIDTH+1)'(1)) >= {1'b0, w_q};
    er2_d = ({2'b0, x_d} + (ADDRESS_WIDTH+2)'(2)) >= {2'b0, w_q};
    sb_d  = (state_q == READ) ? {f_d, el_d, er1_d, er2_d, 1'b1} : '0;
  end

  // Sideband rides alongside the RAM read so it lands together with qA..qD.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RAM_LATENCY; i++) sb_q[i] <= '0;
      frac_out  <= '0;
      edge_l    <= 1'b0;
      edge_r1   <= 1'b0;
      edge_r2   <= 1'b0;
      tap_valid <= 1'b0;
    end else begin
      for (int i = RAM_LATENCY - 1; i > 0; i--) sb_q[i] <= sb_q[i-1];
      sb_q[0] <= sb_d;
      {frac_out, edge_l, edge_r1, edge_r2, tap_valid} <= sb_q[RAM_LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      w_q       <= '0;
      d_q       <= '0;
      step_q    <= '0;
      wcnt_q    <= '0;
      tcnt_q    <= '0;
      acc_q     <= '0;
      dcnt_q    <= '0;
      data_out  <= '0;
      we_out    <= 1'b0;
      addrA_out <= '0;
      addrB_out <= '0;
      addrC_out <= '0;
      addrD_out <= '0;
      busy      <= 1'b0;
      line_done <= 1'b0;
    end else begin
      we_out    <= 1'b0;
      line_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && (src_width != '0)) begin
            w_q     <= src_width;
            d_q     <= dst_width;
            step_q  <= step;
            wcnt_q  <= '0;
            tcnt_q  <= '0;
            acc_q   <= acc_init_d;
            busy    <= 1'b1;
            state_q <= FILL;
          end
        end
        FILL: begin
          if (pix_valid) begin
            we_out    <= 1'b1;
            data_out  <= pix_data;
            addrA_out <= wcnt_q;
            addrB_out <= wcnt_q;
            addrC_out <= wcnt_q;
            addrD_out <= wcnt_q;
            wcnt_q    <= wcnt_q + ADDRESS_WIDTH'(1);
            if (wcnt_q == w_q - ADDRESS_WIDTH'(1)) begin
              dcnt_q  <= '0;
              state_q <= (d_q == '0) ? DRAIN : READ;
            end
          end
        end
        READ: begin
          // Addresses stay consecutive (wrapping) so bank rotation holds; edges go via flags.
          addrA_out <= x_d - ADDRESS_WIDTH'(1);
          addrB_out <= x_d;
          addrC_out <= x_d + ADDRESS_WIDTH'(1);
          addrD_out <= x_d + ADDRESS_WIDTH'(2);
          acc_q     <= acc_q + ACC_W'(step_q);
          tcnt_q    <= tcnt_q + ADDRESS_WIDTH'(1);
          if (tcnt_q == d_q - ADDRESS_WIDTH'(1)) begin
            dcnt_q  <= '0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (dcnt_q == DC_W'(RAM_LATENCY)) begin
            line_done <= 1'b1;
            busy      <= 1'b0;
            state_q   <= IDLE;
          end else begin
            dcnt_q <= dcnt_q + DC_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bicubic_addr_gen.md
Name: bicubic_addr_gen

Overview:
- Upstream control stage for the 4-bank interleaved line buffer in the bicubic scaler.
- Per line: streams W source pixels into the buffer on the write port (addrB/we), then issues one 4-tap read per output pixel with addresses x-1, x, x+1, x+2.
- Emits the matching horizontal phase (fraction) and edge-replication flags, delayed to line up with the buffer's qA..qD outputs for the downstream cubic filter.

Parameters:
- DATA_WIDTH, 24, pixel width (RGB888).
- ADDRESS_WIDTH, 11, line-buffer address width (max 2048 pixels).
- FRAC_WIDTH, 8, fractional bits of the source coordinate and phase output.
- STEP_WIDTH, 16, width of the step input: unsigned Q(STEP_WIDTH-FRAC_WIDTH).FRAC_WIDTH.
- RAM_LATENCY, 6, cycles from addr*_out registered to qA..qD valid at the line buffer.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  pulse; begin a line. Ignored unless IDLE.
- src_width  in  ADDRESS_WIDTH  source pixels per line W, sampled on accepted start.
- dst_width  in  ADDRESS_WIDTH  output pixels per line D, sampled on accepted start.
- step  in  STEP_WIDTH  source increment per output pixel (W/D), sampled on accepted start.
- pix_valid  in  1  source pixel strobe.
- pix_data  in  DATA_WIDTH  source pixel.
- data_out  out  DATA_WIDTH  write data to line buffer.
- we_out  out  1  write enable to line buffer.
- addrA_out, addrB_out, addrC_out, addrD_out  out  ADDRESS_WIDTH each  line-buffer addresses.
- frac_out  out  FRAC_WIDTH  phase aligned with qA..qD.
- edge_l  out  1  x==0: downstream replaces qA with qB.
- edge_r1  out  1  x+1>=W: downstream replaces qC with qB.
- edge_r2  out  1  x+2>=W: downstream replaces qD with qC (or qB if edge_r1).
- tap_valid  out  1  frac/edge outputs valid.
- busy  out  1  not IDLE.
- line_done  out  1  one-cycle pulse at end of line.

Behaviour:
- All outputs registered. Reset value of every output is 0.
- rst at any time: return to IDLE, clear counters and accumulator, flush the sideband delay line (tap_valid=0 next cycle).
- FSM: IDLE -> FILL -> READ -> DRAIN -> IDLE.
- IDLE:
  - start with src_width!=0 latches W, D and step, clears wcnt and acc, then enters FILL.
  - start with src_width==0 is ignored.
- FILL:
  - Each cycle with pix_valid: we_out=1, data_out=pix_data, addrA..D_out=wcnt, wcnt++.
  - Cycles without pix_valid: we_out=0, no advance.
  - After the write at wcnt==W-1, go to READ, or go to DRAIN if D==0.
  - pix_valid outside FILL is ignored.
- READ, one tap per cycle, no stalls:
  - acc is ADDRESS_WIDTH+FRAC_WIDTH+1 bits wide.
  - x = acc>>FRAC_WIDTH; f = acc[FRAC_WIDTH-1:0].
  - If x>W-1, force x=W-1 and f=0.
  - addrB_out=x, addrA_out=x-1, addrC_out=x+1, addrD_out=x+2, all modulo 2^ADDRESS_WIDTH.
  - Addresses are always consecutive. No clamping is applied to the addresses, because the buffer's bank rotation requires four consecutive addresses. Edge handling is done only via the flags.
  - we_out=0 in READ.
  - acc += step each cycle. After D taps, go to DRAIN.
- Sideband:
  - {f, x==0, x+1>=W, x+2>=W, 1} enters a RAM_LATENCY-deep shift register.
  - It appears on frac_out/edge_*/tap_valid exactly RAM_LATENCY cycles after the corresponding addr*_out.
  - Outside READ a 0 is shifted in, so tap_valid=0.
- DRAIN:
  - Wait until the last tap exits the delay line.
  - line_done=1 in the cycle after the last tap_valid.
  - Return to IDLE; busy falls in the same cycle.
- start during FILL/READ/DRAIN is ignored.

Optional Feature:
- Macro: BICUBIC_CENTER_ALIGN_EN.
- Defined: acc initialises to (step>>1) - (1<<(FRAC_WIDTH-1)) for pixel-centre alignment, saturating at 0 if negative.
- Undefined: acc initialises to 0 (corner alignment).

Test Plan:
- FILL:
  - Stimulus: W=8, D=16, step=0x0080; 8 pixel_valid with data 0x000001..0x000008 at 1 pixel every 2 cycles.
  - Response: we_out pulses 8 times, addrB_out 0..7, data matches, we_out low between pixels.
- READ phase and edges:
  - Stimulus: same line as above.
  - Response: addrB_out 0,0,1,1,...,7,7; frac 0,128,0,128,...; addrA_out of the first tap = 0x7FF.
  - edge_l on taps 0-1; edge_r2 on taps 12-15; edge_r1 on taps 14-15.
  - tap_valid high for 16 consecutive cycles, starting 6 cycles after the first read address.
  - line_done pulses 1 cycle after the last tap_valid.
- Overflow clamp:
  - Stimulus: W=4, D=8, step=0x0100.
  - Response: addrB_out 0,1,2,3,3,3,3,3; frac 0 on all taps; edge_r1=1 from tap 3.
- Start ignored / D==0:
  - Stimulus: start pulsed mid-FILL and mid-READ.
  - Response: no restart, counts unchanged.
  - Stimulus: W=4, D=0.
  - Response: FILL only, no tap_valid, line_done, then IDLE.
- Reset mid-READ:
  - Stimulus: assert rst at tap 5 of 16.
  - Response: next cycle busy=0, tap_valid=0, all outputs 0.
  - Stimulus: new start.
  - Response: clean line.
- BICUBIC_CENTER_ALIGN_EN:
  - Stimulus: step=0x0200.
  - Response: first tap x=0, f=128; second tap x=2, f=128.
  - Stimulus: step=0x0080.
  - Response: initial acc saturates to 0.
